// File: rtl/forward_arbiter.sv
// rtl/forward_arbiter.sv - per-slave forward-path request arbiter (optional FWD_ARB_FIXED_PRIO_EN: fixed priority)
module forward_arbiter #(
    parameter  int masters           = 2,
    parameter  int slaves            = 2,
    parameter  int i_am_slave_number = 0,
    localparam int GW                = $clog2(masters) + 1,
    localparam int PW                = (masters > 1) ? $clog2(masters) : 1,
    localparam int DW                = (slaves > 1) ? $clog2(slaves) : 1
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [0:masters-1] master_fifo_empty,
    input  logic [DW-1:0]      master_dest_slave [0:masters-1],
    input  logic               slave_fifo_full,
    output logic [GW-1:0]      grant_master_number,
    output logic               push_to_fifo,
    output logic               grant_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [GW-1:0]      grant;
    logic [PW-1:0]      rr_ptr;
    logic [0:masters-1] req;
    logic               found;
    logic [GW-1:0]      winner;
    logic               req_granted;
    int                 idx;

    always_comb begin
        req = '0;
        for (int i = 0; i < masters; i++) begin
            req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == DW'(i_am_slave_number));
        end
    end

    // Search wraps modulo masters, not modulo 2^PW, so non-power-of-two counts stay fair.
    always_comb begin
        found  = 1'b0;
        winner = GW'(masters);
        idx    = 0;
        for (int k = 0; k < masters; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= masters) begin
                idx = idx - masters;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        req_granted = 1'b0;
        for (int i = 0; i < masters; i++) begin
            if (grant == GW'(i)) begin
                req_granted = req[i];
            end
        end
    end

    assign push_to_fifo        = (state == GRANT) & req_granted & ~slave_fifo_full;
    assign grant_master_number = grant;
    assign grant_valid         = (state == GRANT);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state  <= IDLE;
            grant  <= GW'(masters);
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_granted) begin
                        grant <= GW'(masters);
                        state <= IDLE;
                    end else if (!slave_fifo_full) begin
`ifndef FWD_ARB_FIXED_PRIO_EN
                        rr_ptr <= (grant == GW'(masters - 1)) ? '0 : PW'(grant + GW'(1));
`endif
                        grant  <= GW'(masters);
                        state  <= IDLE;
                    end
                end
                default: begin
                    grant <= GW'(masters);
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_arbiter.sv
// tb/tb_forward_arbiter.sv - scoreboard bench for forward_arbiter (masters=2, slave 0)
module tb_forward_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [0:1] master_fifo_empty;
    logic [0:0] master_dest_slave [0:1];
    logic       slave_fifo_full;
    logic [1:0] grant_master_number;
    logic       push_to_fifo;
    logic       grant_valid;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp_m;

    always #5 ACLK = ~ACLK;

    forward_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(0)) dut (
        .ACLK                (ACLK),
        .ARESETn             (ARESETn),
        .master_fifo_empty   (master_fifo_empty),
        .master_dest_slave   (master_dest_slave),
        .slave_fifo_full     (slave_fifo_full),
        .grant_master_number (grant_master_number),
        .push_to_fifo        (push_to_fifo),
        .grant_valid         (grant_valid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic e0, input logic d0, input logic e1, input logic d1, input logic full);
        master_fifo_empty    = {e0, e1};
        master_dest_slave[0] = d0;
        master_dest_slave[1] = d1;
        slave_fifo_full      = full;
        #1;
    endtask

    task automatic expect_out(input string tag, input int g, input int p, input int v);
        check({tag, "_grant"}, int'(grant_master_number), g);
        check({tag, "_push"}, int'(push_to_fifo), p);
        check({tag, "_valid"}, int'(grant_valid), v);
    endtask

    // Each observed transfer must match the next expected granted master.
    always @(negedge ACLK) begin
        if (push_to_fifo) begin
            if (exp_q.size() == 0) begin
                check("push_unexpected", int'(grant_master_number), -1);
            end else begin
                exp_m = exp_q.pop_front();
                check("push_master", int'(grant_master_number), exp_m);
            end
        end
    end

    initial begin
        ARESETn = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("reset", 2, 0, 0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ARESETn = 1'b1;
        tick();
        expect_out("idle", 2, 0, 0);

        // single request from m1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(1);
        tick();
        expect_out("single", 1, 1, 1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("single_after", 2, 0, 0);
        tick();
        expect_out("single_quiet", 2, 0, 0);

        // both masters requesting continuously
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FWD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(0);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(i % 2);
`endif
        for (int k = 0; k < 8; k++) begin
`ifdef FWD_ARB_FIXED_PRIO_EN
            expect_out($sformatf("rr%0d", k), (k % 2 == 0) ? 0 : 2, (k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 1 : 0);
`else
            if (k == 0) tick();
            else tick();
            expect_out($sformatf("rr%0d", k), (k % 2 == 0) ? (k / 2) % 2 : 2, (k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 1 : 0);
`endif
`ifdef FWD_ARB_FIXED_PRIO_EN
            tick();
`endif
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rr_drain", 2, 0, 0);

        // back-pressure on m0
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("bp_grant", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("bp_hold%0d", i), 0, 0, 1);
        end
        exp_q.push_back(0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("bp_release", 0, 1, 1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("bp_after", 2, 0, 0);

        // withdrawal of m1 while its grant is held by back-pressure
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("wd_grant", 1, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("wd_push", int'(push_to_fifo), 0);
        tick();
        expect_out("wd_drop", 2, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FWD_ARB_FIXED_PRIO_EN
        exp_q.push_back(0);
        tick();
        expect_out("wd_regrant", 0, 1, 1);
`else
        exp_q.push_back(1);
        tick();
        expect_out("wd_regrant", 1, 1, 1);
`endif
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("wd_after", 2, 0, 0);

        // m0 addressed to the other slave
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("dest%0d", i), 2, 0, 0);
        end

        // reset while a grant is held
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("rst_grant", 1, 0, 1);
        ARESETn = 1'b0;
        tick();
        expect_out("rst_mid", 2, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ARESETn = 1'b1;
        exp_q.push_back(0);
        tick();
        expect_out("rst_rrptr", 0, 1, 1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("final_idle", 2, 0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
